decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RISC-V RV32I decode stage, directly downstream of the fetch stage.
- Consumes fetch's PC, aligned 32-bit instruction word and clock-enable.
- Produces a registered decoded bundle for the ALU stage: register addresses, immediate, ALU op, instruction class, system flags, illegal flag.
- Same pipeline-control contract as fetch: per-stage clk_en, global stall, per-stage flush, bubble insertion.

Parameters:
- XLEN, 32, datapath and PC width; only 32 is supported.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- pc_i  in  32  PC of the instruction presented by fetch
- instr_i  in  32  instruction presented by fetch
- clk_en_i  in  1  fetch's clk_en; presented instruction is valid
- stall  in  1  global pipeline stall
- flush  in  1  flush this stage
- clk_en_o  out  1  clock enable for the ALU stage
- pc_o  out  32  registered PC
- rs1_addr_o  out  5  source register 1
- rs2_addr_o  out  5  source register 2
- rd_addr_o  out  5  destination register
- imm_o  out  32  sign-extended immediate
- alu_op_o  out  4  ALU operation (package enum)
- opcode_type_o  out  11  one-hot class: rtype, itype, load, store, branch, jal, jalr, lui, auipc, system, fence
- funct3_o  out  3  funct3 field
- ecall_o  out  1  ECALL
- ebreak_o  out  1  EBREAK
- mret_o  out  1  MRET
- illegal_o  out  1  illegal instruction

Behaviour:
- Reset: every output is 0 (clk_en_o=0, pc_o=0, imm_o=0, all flags 0).
- Decode is combinational; latency is one clock from the sampled instr_i to the outputs.
- Internal stall_bit = stall.
- Capture rule: when !stall_bit && clk_en_i, every data output loads the decoded fields of instr_i and pc_o loads pc_i.
  - When stall_bit is high, all data outputs hold.
  - When clk_en_i is low, data outputs may hold; clk_en_o marks the slot invalid.
- clk_en_o update, in priority order:
  - flush && !stall_bit → 0.
  - else !stall_bit → clk_en_i.
  - else (stalled) → hold.
- Flush while stalled: clk_en_o is forced 0 on the first unstalled edge. A pending-flush flop holds the flush across the stall.
- Immediates:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All sign-extended from instr[31]. R-type and system immediate: 0 for system except CSR address, which is instr[31:20] zero-extended.
- ALU op:
  - R/I: from funct3 plus funct7[5]. SUB only for R-type; SRA for R or I.
  - Branch: EQ/NEQ/LT/GE/LTU/GEU from funct3.
  - Load/store/jal/jalr/lui/auipc: ADD.
- Register addresses: rs1/rs2/rd are always the raw fields instr[19:15]/[24:20]/[11:7]. rd_addr_o is forced 0 for store and branch.
- illegal_o is set for any of:
  - Unknown opcode.
  - instr[1:0] != 2'b11 after optional expansion.
  - R-type funct7 not 0x00/0x20.
  - funct7=0x20 with funct3 not in {ADD, SR}.
  - Branch funct3 in {010, 011}.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 > 010.
  - Instruction 0x00000000 or 0xFFFFFFFF.
- System flags:
  - ecall_o / ebreak_o / mret_o decode exactly 0x00000073 / 0x00100073 / 0x30200073.
  - Any other funct3=000 system encoding is illegal.
- Illegal instructions still propagate with clk_en_o=1 so writeback can trap; all other outputs carry their decoded values.
- Reset asserted mid-operation clears state immediately (asynchronous reset).

Optional Feature:
- Macro: RVC_EN.
- Defined: when instr_i[1:0] != 2'b11, the low 16 bits pass through an RV32C expander before decode, and the expansion is decoded.
  - Reserved or illegal C encodings (including 0x0000) set illegal_o.
- Undefined: no expander; any instr_i[1:0] != 2'b11 sets illegal_o.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants (OPC_LOAD=7'b0000011 etc.);
  - alu_op_e (4-bit: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, EQ, NEQ, LT, GE, LTU, GEU);
  - opcode_type bit indices;
  - funct3 constants.
- One combinational sub-module, rvc_expander (16-bit in, 32-bit out, illegal flag), instantiated only under RVC_EN.

Test Plan:
- ADDI x1,x0,5 (0x00500093), clk_en_i=1 → next edge: rd=1, rs1=0, imm=0x00000005, itype, alu_op=ADD, clk_en_o=1, illegal_o=0.
- BEQ x0,x0,-4 (0xFE000EE3) at pc_i=0x100 → imm=0xFFFFFFFC, branch, alu_op=EQ, rd=0, pc_o=0x100.
- Stall held 3 cycles while instr_i changes to 0x40B50533 (SUB) → outputs and clk_en_o unchanged. First unstalled edge → SUB decoded, rd=10.
- Flush=1 with clk_en_i=1, no stall → next edge clk_en_o=0. Flush pulsed during stall → clk_en_o=0 on first unstalled edge.
- 0x00000000 and 0x0000F00F → illegal_o=1, clk_en_o=1. 0x30200073 → mret_o=1, illegal_o=0.
- 0x00004095 (c.li x1,5) → with RVC_EN: same fields as ADDI x1,x0,5. Without RVC_EN: illegal_o=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, ALU ops, class bit indices and encoding helpers
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_EQ, ALU_NEQ, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
  } alu_op_e;

  localparam int T_RTYPE = 0, T_ITYPE = 1, T_LOAD = 2, T_STORE = 3, T_BRANCH = 4, T_JAL = 5;
  localparam int T_JALR = 6, T_LUI = 7, T_AUIPC = 8, T_SYSTEM = 9, T_FENCE = 10;

  localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100, F3_SR = 3'b101, F3_OR = 3'b110, F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100, F3_BGE = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110, F3_BGEU = 3'b111, F3_WORD = 3'b010, F3_PRIV = 3'b000;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic [10:0] typ;
    logic [2:0]  funct3;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        illegal;
  } dec_t;

  // alt selects SUB/SRA; callers decide when the alternate form is permitted
  function automatic alu_op_e arith_op(logic [2:0] f3, logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return alt ? ALU_SRA : ALU_SRL;
    endcase
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:1] off, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:1] off, logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side inputs, pipeline control and decoded bundle to the ALU stage
interface decode_stage_if;
  import riscv_pkg::*;

  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        clk_en_i;
  logic        stall;
  logic        flush;
  logic        clk_en_o;
  logic [31:0] pc_o;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] imm_o;
  alu_op_e     alu_op_o;
  logic [10:0] opcode_type_o;
  logic [2:0]  funct3_o;
  logic        ecall_o;
  logic        ebreak_o;
  logic        mret_o;
  logic        illegal_o;

  modport master (
    output pc_i, instr_i, clk_en_i, stall, flush,
    input  clk_en_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o, imm_o, alu_op_o,
           opcode_type_o, funct3_o, ecall_o, ebreak_o, mret_o, illegal_o
  );

  modport slave (
    input  pc_i, instr_i, clk_en_i, stall, flush,
    output clk_en_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o, imm_o, alu_op_o,
           opcode_type_o, funct3_o, ecall_o, ebreak_o, mret_o, illegal_o
  );
endinterface

// File: rtl/rvc_expander.sv
// rtl/rvc_expander.sv - RV32C to RV32I expander; reserved encodings flag illegal and yield 0
module rvc_expander import riscv_pkg::*; (
  input  logic [15:0] c,
  output logic [31:0] instr,
  output logic        illegal
);
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [11:0] imm6, u4spn, ulw, ulwsp, uswsp, imm16sp;
  logic [12:0] boff;
  logic [20:0] joff;
  logic [31:0] raw;
  logic        bad;

  assign rd      = c[11:7];
  assign rs2     = c[6:2];
  assign rdp     = {2'b01, c[4:2]};
  assign rs1p    = {2'b01, c[9:7]};
  assign imm6    = {{7{c[12]}}, c[6:2]};
  assign u4spn   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign ulw     = {5'b0, c[5], c[12:10], c[6], 2'b00};
  assign ulwsp   = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
  assign uswsp   = {4'b0, c[8:7], c[12:9], 2'b00};
  assign imm16sp = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0};
  assign boff    = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
  assign joff    = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};

  always_comb begin
    raw = '0;
    bad = 1'b0;
    case ({c[15:13], c[1:0]})
      5'b000_00: begin raw = enc_i(u4spn, 5'd2, F3_ADD, rdp, OPC_OP_IMM); bad = (u4spn == '0); end
      5'b010_00: raw = enc_i(ulw, rs1p, F3_WORD, rdp, OPC_LOAD);
      5'b110_00: raw = enc_s(ulw, rdp, rs1p, F3_WORD, OPC_STORE);
      5'b000_01: raw = enc_i(imm6, rd, F3_ADD, rd, OPC_OP_IMM);
      5'b001_01: raw = enc_j(joff[20:1], 5'd1);
      5'b010_01: raw = enc_i(imm6, 5'd0, F3_ADD, rd, OPC_OP_IMM);
      5'b011_01: begin
        if (rd == 5'd2) begin
          raw = enc_i(imm16sp, 5'd2, F3_ADD, 5'd2, OPC_OP_IMM);
          bad = (imm16sp == '0);
        end else begin
          raw = {{15{c[12]}}, c[6:2], rd, OPC_LUI};
          bad = (imm6 == '0);
        end
      end
      5'b100_01: begin
        case (c[11:10])
          2'b00: begin raw = enc_i({7'b0, c[6:2]}, rs1p, F3_SR, rs1p, OPC_OP_IMM); bad = c[12]; end
          2'b01: begin raw = enc_i({7'b0100000, c[6:2]}, rs1p, F3_SR, rs1p, OPC_OP_IMM); bad = c[12]; end
          2'b10: raw = enc_i(imm6, rs1p, F3_AND, rs1p, OPC_OP_IMM);
          default: begin
            bad = c[12];
            case (c[6:5])
              2'b00:   raw = enc_r(7'h20, rdp, rs1p, F3_ADD, rs1p, OPC_OP);
              2'b01:   raw = enc_r(7'h00, rdp, rs1p, F3_XOR, rs1p, OPC_OP);
              2'b10:   raw = enc_r(7'h00, rdp, rs1p, F3_OR, rs1p, OPC_OP);
              default: raw = enc_r(7'h00, rdp, rs1p, F3_AND, rs1p, OPC_OP);
            endcase
          end
        endcase
      end
      5'b101_01: raw = enc_j(joff[20:1], 5'd0);
      5'b110_01: raw = enc_b(boff[12:1], 5'd0, rs1p, F3_BEQ);
      5'b111_01: raw = enc_b(boff[12:1], 5'd0, rs1p, F3_BNE);
      5'b000_10: begin raw = enc_i({7'b0, c[6:2]}, rd, F3_SLL, rd, OPC_OP_IMM); bad = c[12]; end
      5'b010_10: begin raw = enc_i(ulwsp, 5'd2, F3_WORD, rd, OPC_LOAD); bad = (rd == 5'd0); end
      5'b100_10: begin
        if (!c[12]) begin
          if (rs2 == 5'd0) begin raw = enc_i(12'd0, rd, 3'b000, 5'd0, OPC_JALR); bad = (rd == 5'd0); end
          else raw = enc_r(7'h00, rs2, 5'd0, F3_ADD, rd, OPC_OP);
        end else if (rs2 == 5'd0) begin
          raw = (rd == 5'd0) ? 32'h0010_0073 : enc_i(12'd0, rd, 3'b000, 5'd1, OPC_JALR);
        end else begin
          raw = enc_r(7'h00, rs2, rd, F3_ADD, rd, OPC_OP);
        end
      end
      5'b110_10: raw = enc_s(uswsp, rs2, 5'd2, F3_WORD, OPC_STORE);
      default: bad = 1'b1;
    endcase
  end

  assign illegal = bad;
  assign instr   = bad ? 32'h0 : raw;
endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with registered bundle; RVC_EN adds the RV32C expander
module decode_stage import riscv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rstn,
  decode_stage_if.slave bus
);
  logic [31:0]     ins;
  logic            pre_ill;
  logic [6:0]      f7;
  logic [2:0]      f3;
  dec_t            dec, dec_q;
  logic [XLEN-1:0] pc_q;
  logic            ce_q, flush_pend;

`ifdef RVC_EN
  logic [31:0] exp_ins;
  logic        exp_ill;

  rvc_expander u_rvc (.c(bus.instr_i[15:0]), .instr(exp_ins), .illegal(exp_ill));

  assign ins     = (bus.instr_i[1:0] == 2'b11) ? bus.instr_i : exp_ins;
  assign pre_ill = (bus.instr_i[1:0] != 2'b11) && exp_ill;
`else
  assign ins     = bus.instr_i;
  assign pre_ill = 1'b0;
`endif

  assign f7 = ins[31:25];
  assign f3 = ins[14:12];

  always_comb begin
    dec         = '0;
    dec.rs1     = ins[19:15];
    dec.rs2     = ins[24:20];
    dec.rd      = ins[11:7];
    dec.funct3  = f3;
    dec.alu_op  = ALU_ADD;
    dec.illegal = pre_ill;
    case (ins[6:0])
      OPC_OP: begin
        dec.typ[T_RTYPE] = 1'b1;
        dec.alu_op       = arith_op(f3, f7[5]);
        if (f7 != 7'h00 && f7 != 7'h20) dec.illegal = 1'b1;
        if (f7 == 7'h20 && f3 != F3_ADD && f3 != F3_SR) dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.typ[T_ITYPE] = 1'b1;
        dec.imm          = {{20{ins[31]}}, ins[31:20]};
        dec.alu_op       = arith_op(f3, ins[30] && f3 == F3_SR);
      end
      OPC_LOAD: begin
        dec.typ[T_LOAD] = 1'b1;
        dec.imm         = {{20{ins[31]}}, ins[31:20]};
        if (f3 == 3'b011 || f3[2:1] == 2'b11) dec.illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.typ[T_STORE] = 1'b1;
        dec.imm          = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        dec.rd           = '0;
        if (f3 > F3_WORD) dec.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.typ[T_BRANCH] = 1'b1;
        dec.imm           = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        dec.rd            = '0;
        case (f3)
          F3_BEQ:  dec.alu_op = ALU_EQ;
          F3_BNE:  dec.alu_op = ALU_NEQ;
          F3_BLT:  dec.alu_op = ALU_LT;
          F3_BGE:  dec.alu_op = ALU_GE;
          F3_BLTU: dec.alu_op = ALU_LTU;
          F3_BGEU: dec.alu_op = ALU_GEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.typ[T_JAL] = 1'b1;
        dec.imm        = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec.typ[T_JALR] = 1'b1;
        dec.imm         = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_LUI: begin
        dec.typ[T_LUI] = 1'b1;
        dec.imm        = {ins[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec.typ[T_AUIPC] = 1'b1;
        dec.imm          = {ins[31:12], 12'b0};
      end
      OPC_SYSTEM: begin
        dec.typ[T_SYSTEM] = 1'b1;
        if (f3 == F3_PRIV) begin
          dec.ecall   = (ins == 32'h0000_0073);
          dec.ebreak  = (ins == 32'h0010_0073);
          dec.mret    = (ins == 32'h3020_0073);
          dec.illegal = dec.illegal | !(dec.ecall | dec.ebreak | dec.mret);
        end else begin
          dec.imm = {20'b0, ins[31:20]};
        end
      end
      OPC_MISC_MEM: begin
        dec.typ[T_FENCE] = 1'b1;
        dec.imm          = {{20{ins[31]}}, ins[31:20]};
        if (f3 != 3'b000) dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (ins[1:0] != 2'b11 || ins == 32'h0 || ins == 32'hFFFF_FFFF) dec.illegal = 1'b1;
  end

  // A flush that lands during a stall is remembered until the stall lifts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ce_q       <= 1'b0;
      flush_pend <= 1'b0;
      dec_q      <= '0;
      pc_q       <= '0;
    end else begin
      if (!bus.stall) begin
        ce_q       <= (bus.flush || flush_pend) ? 1'b0 : bus.clk_en_i;
        flush_pend <= 1'b0;
      end else if (bus.flush) begin
        flush_pend <= 1'b1;
      end
      if (!bus.stall && bus.clk_en_i) begin
        dec_q <= dec;
        pc_q  <= bus.pc_i;
      end
    end
  end

  assign bus.clk_en_o      = ce_q;
  assign bus.pc_o          = pc_q;
  assign bus.rs1_addr_o    = dec_q.rs1;
  assign bus.rs2_addr_o    = dec_q.rs2;
  assign bus.rd_addr_o     = dec_q.rd;
  assign bus.imm_o         = dec_q.imm;
  assign bus.alu_op_o      = dec_q.alu_op;
  assign bus.opcode_type_o = dec_q.typ;
  assign bus.funct3_o      = dec_q.funct3;
  assign bus.ecall_o       = dec_q.ecall;
  assign bus.ebreak_o      = dec_q.ebreak;
  assign bus.mret_o        = dec_q.mret;
  assign bus.illegal_o     = dec_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and random checks of decode_stage against a field-level decode model
module tb_decode_stage;
  import riscv_pkg::*;

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [10:0] typ;
    logic [2:0]  f3;
    logic        ec, eb, mr, ill;
  } mdl_t;

  localparam logic [3:0] RR_TAB [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [3:0] BR_TAB [8] = '{ALU_EQ, ALU_NEQ, ALU_ADD, ALU_ADD, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  mdl_t        exp_d;
  logic [31:0] exp_pc;
  logic        exp_ce, exp_pend;

  decode_stage_if bus();
  decode_stage dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  function automatic mdl_t ref_dec(input logic [31:0] w);
    mdl_t d;
    logic signed [31:0] sw;
    logic [2:0] f3;
    logic [6:0] f7;
    sw = w;
    f3 = w[14:12];
    f7 = w[31:25];
    d = '0;
    d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7]; d.f3 = f3; d.op = ALU_ADD;
    case (w[6:0])
      7'b0110011: begin
        d.typ = 11'(1) << T_RTYPE;
        d.op = RR_TAB[f3];
        if (w[30] && f3 == 3'd0) d.op = ALU_SUB;
        if (w[30] && f3 == 3'd5) d.op = ALU_SRA;
        d.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'b0010011: begin
        d.typ = 11'(1) << T_ITYPE; d.imm = 32'(sw >>> 20);
        d.op = (f3 == 3'd5 && w[30]) ? ALU_SRA : RR_TAB[f3];
      end
      7'b0000011: begin
        d.typ = 11'(1) << T_LOAD; d.imm = 32'(sw >>> 20);
        d.ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      7'b0100011: begin
        d.typ = 11'(1) << T_STORE; d.rd = 0; d.ill = (f3 > 3'd2);
        d.imm = (32'(sw >>> 25) << 5) | 32'(w[11:7]);
      end
      7'b1100011: begin
        d.typ = 11'(1) << T_BRANCH; d.rd = 0; d.op = BR_TAB[f3];
        d.ill = (f3 == 3'd2 || f3 == 3'd3);
        d.imm = (32'(sw >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      end
      7'b1101111: begin
        d.typ = 11'(1) << T_JAL;
        d.imm = (32'(sw >>> 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      end
      7'b1100111: begin d.typ = 11'(1) << T_JALR; d.imm = 32'(sw >>> 20); end
      7'b0110111: begin d.typ = 11'(1) << T_LUI; d.imm = w & 32'hFFFF_F000; end
      7'b0010111: begin d.typ = 11'(1) << T_AUIPC; d.imm = w & 32'hFFFF_F000; end
      7'b1110011: begin
        d.typ = 11'(1) << T_SYSTEM;
        if (f3 == 3'd0) begin
          d.ec = (w == 32'h0000_0073); d.eb = (w == 32'h0010_0073); d.mr = (w == 32'h3020_0073);
          d.ill = !(d.ec || d.eb || d.mr);
        end else d.imm = w >> 20;
      end
      7'b0001111: begin d.typ = 11'(1) << T_FENCE; d.imm = 32'(sw >>> 20); d.ill = (f3 != 3'd0); end
      default: d.ill = 1'b1;
    endcase
    if (w[1:0] != 2'b11 || w == 32'h0 || w == 32'hFFFF_FFFF) d.ill = 1'b1;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("clk_en_o", 32'(bus.clk_en_o), 32'(exp_ce));
    chk("pc_o", bus.pc_o, exp_pc);
    chk("rs1", 32'(bus.rs1_addr_o), 32'(exp_d.rs1));
    chk("rs2", 32'(bus.rs2_addr_o), 32'(exp_d.rs2));
    chk("rd", 32'(bus.rd_addr_o), 32'(exp_d.rd));
    chk("imm", bus.imm_o, exp_d.imm);
    chk("alu_op", 32'(bus.alu_op_o), 32'(exp_d.op));
    chk("opcode_type", 32'(bus.opcode_type_o), 32'(exp_d.typ));
    chk("funct3", 32'(bus.funct3_o), 32'(exp_d.f3));
    chk("ecall", 32'(bus.ecall_o), 32'(exp_d.ec));
    chk("ebreak", 32'(bus.ebreak_o), 32'(exp_d.eb));
    chk("mret", 32'(bus.mret_o), 32'(exp_d.mr));
    chk("illegal", 32'(bus.illegal_o), 32'(exp_d.ill));
  endtask

  task automatic reset_model();
    exp_d = '0; exp_pc = '0; exp_ce = 1'b0; exp_pend = 1'b0;
  endtask

  // mw is the 32-bit word the model decodes (differs from w only for compressed input)
  task automatic step(input logic [31:0] pc, input logic [31:0] w, input logic [31:0] mw,
                      input logic ce, input logic st, input logic fl);
    bus.pc_i = pc; bus.instr_i = w; bus.clk_en_i = ce; bus.stall = st; bus.flush = fl;
    @(posedge clk);
    #1;
    if (!st && ce) begin exp_d = ref_dec(mw); exp_pc = pc; end
    if (!st) begin exp_ce = (fl || exp_pend) ? 1'b0 : ce; exp_pend = 1'b0; end
    else if (fl) exp_pend = 1'b1;
    n_vec++;
    check_all();
  endtask

  task automatic go(input logic [31:0] pc, input logic [31:0] w, input logic ce,
                    input logic st, input logic fl);
    step(pc, w, w, ce, st, fl);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opcs [11];
    logic [31:0] spec [6];
    int k;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
             7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0001111};
    spec = '{32'h0, 32'hFFFF_FFFF, 32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h0010_0093};
    w = $urandom;
    k = $urandom_range(0, 13);
    if (k < 11) begin
      w[6:0] = opcs[k];
      if (k == 0 && $urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      if (k == 9 && $urandom_range(0, 1) == 0) w[14:12] = 3'b000;
    end else if (k == 11) begin
      w = spec[$urandom_range(0, 5)];
    end else begin
`ifdef RVC_EN
      w[1:0] = 2'b11;
`endif
    end
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    reset_model();
    bus.pc_i = '0; bus.instr_i = '0; bus.clk_en_i = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    check_all();
    rstn = 1'b1;

    go(32'h0, 32'h0050_0093, 1, 0, 0);
    chk("addi_rd", 32'(bus.rd_addr_o), 32'd1);
    chk("addi_rs1", 32'(bus.rs1_addr_o), 32'd0);
    chk("addi_imm", bus.imm_o, 32'h5);
    chk("addi_type", 32'(bus.opcode_type_o), 32'h2);
    chk("addi_op", 32'(bus.alu_op_o), 32'(ALU_ADD));
    chk("addi_ce", 32'(bus.clk_en_o), 32'd1);
    chk("addi_ill", 32'(bus.illegal_o), 32'd0);

    go(32'h100, 32'hFE00_0EE3, 1, 0, 0);
    chk("beq_imm", bus.imm_o, 32'hFFFF_FFFC);
    chk("beq_type", 32'(bus.opcode_type_o), 32'h10);
    chk("beq_op", 32'(bus.alu_op_o), 32'(ALU_EQ));
    chk("beq_rd", 32'(bus.rd_addr_o), 32'd0);
    chk("beq_pc", bus.pc_o, 32'h100);

    for (int i = 0; i < 3; i++) begin
      go(32'h104, 32'h40B5_0533, 1, 1, 0);
      chk("stall_pc", bus.pc_o, 32'h100);
      chk("stall_imm", bus.imm_o, 32'hFFFF_FFFC);
    end
    go(32'h104, 32'h40B5_0533, 1, 0, 0);
    chk("sub_rd", 32'(bus.rd_addr_o), 32'd10);
    chk("sub_op", 32'(bus.alu_op_o), 32'(ALU_SUB));

    go(32'h108, 32'h0050_0093, 1, 0, 1);
    chk("flush_ce", 32'(bus.clk_en_o), 32'd0);
    go(32'h10C, 32'h0050_0093, 1, 0, 0);
    go(32'h110, 32'h0050_0093, 1, 1, 1);
    go(32'h110, 32'h0050_0093, 1, 1, 0);
    chk("flush_stall_hold", 32'(bus.clk_en_o), 32'd1);
    go(32'h110, 32'h0050_0093, 1, 0, 0);
    chk("flush_pend_ce", 32'(bus.clk_en_o), 32'd0);
    go(32'h114, 32'h0050_0093, 0, 0, 0);
    chk("ce_low", 32'(bus.clk_en_o), 32'd0);

    go(32'h118, 32'h0000_0000, 1, 0, 0);
    chk("zero_ill", 32'(bus.illegal_o), 32'd1);
    chk("zero_ce", 32'(bus.clk_en_o), 32'd1);
    go(32'h11C, 32'h0000_F00F, 1, 0, 0);
    chk("f00f_ill", 32'(bus.illegal_o), 32'd1);
    go(32'h120, 32'h3020_0073, 1, 0, 0);
    chk("mret", 32'(bus.mret_o), 32'd1);
    chk("mret_ill", 32'(bus.illegal_o), 32'd0);
    go(32'h124, 32'h0000_0073, 1, 0, 0);
    go(32'h128, 32'h0010_0073, 1, 0, 0);
    go(32'h12C, 32'hFFFF_FFFF, 1, 0, 0);

`ifdef RVC_EN
    step(32'h130, 32'h0000_4095, 32'h0050_0093, 1, 0, 0);
    chk("cli_rd", 32'(bus.rd_addr_o), 32'd1);
    chk("cli_imm", bus.imm_o, 32'h5);
    chk("cli_ill", 32'(bus.illegal_o), 32'd0);
`else
    go(32'h130, 32'h0000_4095, 1, 0, 0);
    chk("cli_ill", 32'(bus.illegal_o), 32'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      w = rand_instr();
      go($urandom, w, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
      if (i == 200) begin
        #2;
        rstn = 1'b0;
        #1;
        reset_model();
        check_all();
        #1;
        rstn = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
